// File: rtl/seg7_scan_pkg.sv
// seg7_scan_pkg: shared 7-segment display constants and hex decode table.
package seg7_scan_pkg;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    // Active-low {g..a} patterns, entry n at bits [7n +: 7].
    localparam logic [16*7-1:0] HEX_SEG = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };
    localparam int STROBE_PERIOD = 2**17;
endpackage

// File: rtl/seg7_scan_hex_to_seg7.sv
// hex_to_seg7: combinational nibble to active-low 7-segment decoder.
module hex_to_seg7
    import seg7_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = HEX_SEG[nibble*7 +: 7];
endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed hex display driver with frame-latched inputs,
// leading-zero blanking and blink.
module seg7_scan
    import seg7_scan_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int BLINK_TICKS = 381
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    seg_tick,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    input  logic                    blink,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame
);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int BW = $clog2(BLINK_TICKS + 1);
    logic [IW-1:0] idx;
    logic [BW-1:0] bcnt;
    logic running, hidden, blank_sh, blink_sh, wrap, bwrap, off;
    logic [4*NUM_DIGITS-1:0] value_sh;
    logic [NUM_DIGITS-1:0] dp_sh;
    logic [6:0] hex;
    assign wrap  = idx == IW'(NUM_DIGITS - 1);
    assign bwrap = bcnt == BW'(BLINK_TICKS - 1);
    // A digit is dark before the first frame, as a leading zero, or in the hidden blink phase.
    assign off = !running || (blank_sh && idx != '0 && (value_sh >> (4*idx)) == '0) || (blink_sh && hidden);
    hex_to_seg7 dec (.nibble(value_sh[4*idx +: 4]), .seg(hex));
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            idx      <= IW'(NUM_DIGITS - 1);
            running  <= 1'b0;
            value_sh <= '0;
            dp_sh    <= '0;
            blank_sh <= 1'b0;
            blink_sh <= 1'b0;
            bcnt     <= '0;
            hidden   <= 1'b0;
            frame    <= 1'b0;
            an       <= '1;
            seg      <= SEG_BLANK;
            dp       <= 1'b1;
        end else begin
            frame <= seg_tick && wrap;
            an    <= off ? '1 : ~(NUM_DIGITS'(1) << idx);
            seg   <= off ? SEG_BLANK : hex;
            dp    <= off | ~dp_sh[idx];
            if (seg_tick) begin
                idx    <= wrap ? '0 : idx + 1'b1;
                bcnt   <= bwrap ? '0 : bcnt + 1'b1;
                hidden <= hidden ^ bwrap;
                if (wrap) begin
                    value_sh <= value;
                    dp_sh    <= dp_in;
                    blank_sh <= blank_lz;
                    blink_sh <= blink;
                    running  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: scoreboard bench; driver queues hand-computed digits, monitor
// compares them when each strobe's result reaches the outputs.
module tb_seg7_scan;
    import seg7_scan_pkg::*;
    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } out_t;
    localparam out_t BLANK = {4'hF, SEG_BLANK, 1'b1};
    logic clk = 0, clr = 0, seg_tick = 0, blank_lz = 0, blink = 0;
    logic [15:0] value = '0;
    logic [3:0] dp_in = '0, an;
    logic [6:0] seg;
    logic dp, frame;
    logic [1:0] h;
    out_t oq[$], cur;
    logic fq[$];
    int compared = 0, mismatched = 0;

    seg7_scan #(.NUM_DIGITS(4), .BLINK_TICKS(4)) dut (
        .clk(clk), .clr(clr), .seg_tick(seg_tick), .value(value), .dp_in(dp_in),
        .blank_lz(blank_lz), .blink(blink), .an(an), .seg(seg), .dp(dp), .frame(frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Strobe history: h[0] = strobe sampled at the last edge, h[1] = the edge before.
    always @(posedge clk or posedge clr) h <= clr ? 2'b00 : {h[0], seg_tick};

    always @(negedge clk) begin
        if (clr) cur = BLANK;
        if (h[0]) check("frame", 12'(frame), fq.size() != 0 ? 12'(fq.pop_front()) : 12'hFFF);
        else check("frame_idle", 12'(frame), 12'd0);
        if (h[1]) begin
            if (oq.size() != 0) cur = oq.pop_front();
            else begin
                mismatched++;
                $display("FAIL out_queue: output strobe with no expectation at %0t", $time);
            end
        end
        check("out", {an, seg, dp}, cur);
    end

    always @(posedge clr) begin
        #1;
        check("clr_async_out", {an, seg, dp}, BLANK);
        check("clr_async_frame", 12'(frame), 12'd0);
    end

    task automatic strobe(input logic [3:0] a, input logic [6:0] s, input logic d, input logic f);
        seg_tick = 1;
        oq.push_back({a, s, d});
        fq.push_back(f);
        @(posedge clk);
        #1 seg_tick = 0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset();
        #3 clr = 1;
        oq.delete();
        fq.delete();
        repeat (3) @(posedge clk);
        #4 clr = 0;
        gap(1);
    endtask

    initial begin
        cur = BLANK;
        reset();
        gap(1000);
        reset();
        value = 16'h12AF;
        strobe(4'b1110, 7'b0001110, 1, 1); gap(2);
        strobe(4'b1101, 7'b0001000, 1, 0); gap(2);
        strobe(4'b1011, 7'b0100100, 1, 0); gap(2);
        strobe(4'b0111, 7'b1111001, 1, 0); gap(3);
        reset();
        value = 16'h0050; blank_lz = 1;
        strobe(4'b1110, 7'b1000000, 1, 1);
        strobe(4'b1101, 7'b0010010, 1, 0);
        strobe(4'b1111, SEG_BLANK,  1, 0);
        strobe(4'b1111, SEG_BLANK,  1, 0);
        value = 16'h0000;
        strobe(4'b1110, 7'b1000000, 1, 1);
        strobe(4'b1111, SEG_BLANK,  1, 0);
        strobe(4'b1111, SEG_BLANK,  1, 0);
        strobe(4'b1111, SEG_BLANK,  1, 0);
        gap(3);
        reset();
        blank_lz = 0; value = 16'h1234;
        strobe(4'b1110, 7'b0011001, 1, 1);
        strobe(4'b1101, 7'b0110000, 1, 0);
        value = 16'hFFFF;
        strobe(4'b1011, 7'b0100100, 1, 0);
        strobe(4'b0111, 7'b1111001, 1, 0);
        strobe(4'b1110, 7'b0001110, 1, 1);
        strobe(4'b1101, 7'b0001110, 1, 0);
        strobe(4'b1011, 7'b0001110, 1, 0);
        strobe(4'b0111, 7'b0001110, 1, 0);
        gap(3);
        reset();
        // Phase toggles on every 4th strobe since reset: strobes 4-7 and 12-15 are hidden.
        value = 16'h8888; blink = 1; dp_in = 4'b0010;
        for (int n = 1; n <= 16; n++) begin
            automatic int d = (n - 1) % 4;
            automatic logic vis = ((n / 4) % 2) == 0;
            strobe(vis ? ~(4'b0001 << d) : 4'b1111, vis ? 7'b0000000 : SEG_BLANK,
                   !(vis && d == 1), d == 0);
        end
        gap(3);
        reset();
        blink = 0; dp_in = 4'b0000; value = 16'h1234;
        strobe(4'b1110, 7'b0011001, 1, 1);
        strobe(4'b1101, 7'b0110000, 1, 0);
        strobe(4'b1011, 7'b0100100, 1, 0);
        strobe(4'b0111, 7'b1111001, 1, 0);
        strobe(4'b1110, 7'b0011001, 1, 1);
        reset();
        value = 16'hABCD;
        gap(2);
        strobe(4'b1110, 7'b0100001, 1, 1);
        strobe(4'b1101, 7'b1000110, 1, 0);
        strobe(4'b1011, 7'b0000011, 1, 0);
        strobe(4'b0111, 7'b0001000, 1, 0);
        gap(5);
        if (oq.size() != 0 || fq.size() != 0) begin
            mismatched++;
            $display("FAIL leftover: %0d outputs and %0d frames never observed", oq.size(), fq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
